// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: gate FSM states, BCD constants,
// and the default system clock rate (also used by the display refresh timer).
package freq_meter_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 32'd50_000_000;

  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    ST_GATE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_CLEAR = 2'd2
  } gate_state_e;

  // Next value of one decimal digit: 9 wraps to 0, anything else counts up.
  function automatic logic [3:0] bcd_next(input logic [3:0] d);
    return (d == BCD_NINE) ? 4'd0 : (d + 4'd1);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the cascaded BCD accumulator. carry is combinational
// so a whole chain of digits ripples within a single clock cycle.
module bcd_digit
  import freq_meter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_r;

  assign q     = q_r;
  assign carry = inc & (q_r == BCD_NINE);

  // Digit register: reset/clear to zero, otherwise count on inc.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 4'd0;
    end else if (clr) begin
      q_r <= 4'd0;
    end else if (inc) begin
      q_r <= bcd_next(q_r);
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/freq_gate_counter.sv
// Gate-window edge counter for the frequency meter. Counts rising edges of
// sigdin over GATE_CYCLES clocks, then publishes a packed BCD result with a
// one-cycle valid strobe, overflow flag and range tag.
// Optional feature macro FREQ_GATE_HOLD_EN adds a 'hold' input that freezes
// the published result (windows are discarded while it is high at LATCH).
module freq_gate_counter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
  parameter int unsigned GATE_CYCLES = CLK_HZ,
  parameter int unsigned DIGITS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sigdin,
  input  logic                  SW2,
`ifdef FREQ_GATE_HOLD_EN
  input  logic                  hold,
`endif
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  ovf,
  output logic                  range_x10
);

  localparam int unsigned CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

  logic                 s1_r, s2_r, s3_r;
  logic                 edge_s;
  gate_state_e          state_r, state_nxt_s;
  logic [CW-1:0]        gate_cnt_r;
  logic                 range_start_r;
  logic                 ovf_sticky_r;
  logic [4*DIGITS-1:0]  acc_s;
  logic [DIGITS-1:0]    inc_s;
  logic [DIGITS-1:0]    carry_s;
  logic                 clr_s;
  logic                 hold_s;
  logic                 publish_s;

`ifdef FREQ_GATE_HOLD_EN
  assign hold_s = hold;
`else
  assign hold_s = 1'b0;
`endif

  assign edge_s    = s2_r & ~s3_r;
  assign clr_s     = (state_r == ST_CLEAR);
  // Once saturated the chain stops counting; the published value is forced
  // to all nines, so the rolled-over digits are never visible.
  assign inc_s[0]  = (state_r == ST_GATE) & edge_s & ~ovf_sticky_r;
  assign publish_s = (state_r == ST_LATCH) & (SW2 == range_start_r) & ~hold_s;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_s),
        .inc   (inc_s[g]),
        .q     (acc_s[4*g +: 4]),
        .carry (carry_s[g])
      );
    end
    for (g = 1; g < DIGITS; g++) begin : g_chain
      assign inc_s[g] = carry_s[g-1];
    end
  endgenerate

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sigdin;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Gate FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_GATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Gate FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_GATE: begin
        if (gate_cnt_r == GATE_LAST) begin
          state_nxt_s = ST_LATCH;
        end else begin
          state_nxt_s = ST_GATE;
        end
      end
      ST_LATCH: state_nxt_s = ST_CLEAR;
      ST_CLEAR: state_nxt_s = ST_GATE;
      default:  state_nxt_s = ST_GATE;
    endcase
  end

  // Gate counter and range sample taken on the first gate cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt_r    <= '0;
      range_start_r <= 1'b0;
    end else begin
      case (state_r)
        ST_GATE: begin
          if (gate_cnt_r != GATE_LAST) begin
            gate_cnt_r <= gate_cnt_r + CW'(1);
          end
          if (gate_cnt_r == '0) begin
            range_start_r <= SW2;
          end
        end
        ST_CLEAR: gate_cnt_r <= '0;
        default:  gate_cnt_r <= gate_cnt_r;
      endcase
    end
  end

  // Sticky overflow: set by a carry out of the top digit, cleared per window.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky_r <= 1'b0;
    end else if (clr_s) begin
      ovf_sticky_r <= 1'b0;
    end else if (carry_s[DIGITS-1]) begin
      ovf_sticky_r <= 1'b1;
    end else begin
      ovf_sticky_r <= ovf_sticky_r;
    end
  end

  // Published result registers; valid strobes during the following CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd       <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      range_x10 <= 1'b0;
    end else begin
      valid <= publish_s;
      if (publish_s) begin
        bcd       <= ovf_sticky_r ? ALL_NINES : acc_s;
        ovf       <= ovf_sticky_r;
        range_x10 <= range_start_r;
      end
    end
  end

endmodule
